// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, results held until the next accepted command.
// Latency DIVIDEND_W+1 cycles from accept to done (1 for divide-by-zero); func is ignored while busy, no queueing.
module seq_divider #(
  parameter int DIVIDEND_W = 4,
  parameter int DIVISOR_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  func,
  input  logic [DIVIDEND_W-1:0] in1,
  input  logic [DIVISOR_W-1:0]  in2,
  output logic [DIVIDEND_W-1:0] quot,
  output logic [DIVISOR_W-1:0]  rem,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero
);

  localparam int CNT_W = $clog2(DIVIDEND_W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [DIVIDEND_W-1:0] r_dvd;
  logic [DIVISOR_W-1:0]  r_dvs;
  logic [DIVISOR_W-1:0]  r_part;
  logic [DIVIDEND_W-1:0] r_quot;
  logic [DIVISOR_W-1:0]  r_rem;
  logic                  r_dbz;

  logic                  w_accept;
  logic                  w_zero;
  logic                  w_last;
  logic [DIVISOR_W:0]    w_shift;
  logic                  w_ge;
  logic [DIVISOR_W-1:0]  w_part_next;

  assign w_accept = func && (r_state != S_CALC);
  assign w_zero   = (in2 == '0);
  assign w_last   = (r_cnt == CNT_W'(DIVIDEND_W - 1));

  // The stored partial remainder is always below the divisor, so DIVISOR_W
  // bits hold it; only the shifted trial value needs the extra bit.
  assign w_shift     = {r_part, r_dvd[DIVIDEND_W-1]};
  assign w_ge        = (w_shift >= {1'b0, r_dvs});
  assign w_part_next = w_ge ? DIVISOR_W'(w_shift - {1'b0, r_dvs})
                            : w_shift[DIVISOR_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next_state = w_zero ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (w_last) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        if (w_accept) begin
          w_next_state = w_zero ? S_DONE : S_CALC;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // The dividend register doubles as the quotient accumulator: each step
  // shifts out a dividend bit at the top and shifts in a quotient bit below.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_dvd  <= '0;
      r_dvs  <= '0;
      r_part <= '0;
      r_quot <= '0;
      r_rem  <= '0;
      r_dbz  <= 1'b0;
    end else if (w_accept) begin
      if (w_zero) begin
        r_quot <= '1;
        r_rem  <= '0;
        r_dbz  <= 1'b1;
      end else begin
        r_dvd  <= in1;
        r_dvs  <= in2;
        r_part <= '0;
        r_cnt  <= '0;
      end
    end else if (r_state == S_CALC) begin
      r_dvd  <= {r_dvd[DIVIDEND_W-2:0], w_ge};
      r_part <= w_part_next;
      r_cnt  <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_quot <= {r_dvd[DIVIDEND_W-2:0], w_ge};
        r_rem  <= w_part_next;
        r_dbz  <= 1'b0;
      end
    end
  end

  assign quot        = r_quot;
  assign rem         = r_rem;
  assign div_by_zero = r_dbz;
  assign busy        = (r_state == S_CALC);
  assign done        = (r_state == S_DONE);

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider at default widths: vector table, operand sweep and multi-cycle corner sequences.
module tb_seq_divider;

  logic       clk;
  logic       rst;
  logic       func;
  logic [3:0] in1;
  logic [1:0] in2;
  logic [3:0] quot;
  logic [1:0] rem;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  int checks;
  int failures;
  int overlap;

  seq_divider #(.DIVIDEND_W(4), .DIVISOR_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .func       (func),
    .in1        (in1),
    .in2        (in2),
    .quot       (quot),
    .rem        (rem),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (busy && done) overlap++;
  end

  typedef struct {
    logic [3:0] a;
    logic [1:0] b;
    logic [3:0] q;
    logic [1:0] r;
    logic       z;
    int         lat;
    int         nbusy;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Accepts one command and returns at the negedge of the done cycle.
  // lat counts accept-relative edges: 0 means done right after the accepting edge.
  task automatic run_op(input logic [3:0] a, input logic [1:0] b,
                        output int lat, output int nbusy);
    @(negedge clk);
    func = 1'b1;
    in1  = a;
    in2  = b;
    @(posedge clk);
    @(negedge clk);
    func  = 1'b0;
    in1   = 4'($urandom);
    in2   = 2'($urandom);
    lat   = -1;
    nbusy = 0;
    for (int n = 0; n < 20; n++) begin
      if (busy) nbusy++;
      if (done) begin
        lat = n;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int lat;
    int nbusy;
    int ndone;
    int k;
    int held_bad;
    logic [3:0] cq;
    logic [1:0] cr;

    checks   = 0;
    failures = 0;
    overlap  = 0;
    func     = 1'b0;
    in1      = '0;
    in2      = '0;

    vecs[0] = '{4'd13, 2'd3, 4'd4,  2'd1, 1'b0, 4, 4};
    vecs[1] = '{4'd15, 2'd1, 4'd15, 2'd0, 1'b0, 4, 4};
    vecs[2] = '{4'd2,  2'd3, 4'd0,  2'd2, 1'b0, 4, 4};
    vecs[3] = '{4'd0,  2'd2, 4'd0,  2'd0, 1'b0, 4, 4};
    vecs[4] = '{4'd9,  2'd0, 4'd15, 2'd0, 1'b1, 0, 0};
    vecs[5] = '{4'd9,  2'd2, 4'd4,  2'd1, 1'b0, 4, 4};
    vecs[6] = '{4'd15, 2'd3, 4'd5,  2'd0, 1'b0, 4, 4};
    vecs[7] = '{4'd14, 2'd3, 4'd4,  2'd2, 1'b0, 4, 4};
    vecs[8] = '{4'd8,  2'd0, 4'd15, 2'd0, 1'b1, 0, 0};

    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("reset_quot", int'(quot), 0);
    check("reset_rem", int'(rem), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_dbz", int'(div_by_zero), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].a, vecs[i].b, lat, nbusy);
      check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_busy_cycles", i), nbusy, vecs[i].nbusy);
      check($sformatf("vec%0d_quot", i), int'(quot), int'(vecs[i].q));
      check($sformatf("vec%0d_rem", i), int'(rem), int'(vecs[i].r));
      check($sformatf("vec%0d_dbz", i), int'(div_by_zero), int'(vecs[i].z));
    end

    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 4; b++) begin
        run_op(4'(a), 2'(b), lat, nbusy);
        check($sformatf("sweep_%0d_by_%0d_quot", a, b), int'(quot), a / b);
        check($sformatf("sweep_%0d_by_%0d_rem", a, b), int'(rem), a % b);
        check($sformatf("sweep_%0d_by_%0d_inv", a, b),
              int'(quot) * b + int'(rem) == a && int'(rem) < b, 1);
      end
    end

    // Command presented while busy must be dropped.
    @(negedge clk);
    func = 1'b1; in1 = 4'd13; in2 = 2'd3;
    @(negedge clk);
    func = 1'b0;
    @(negedge clk);
    check("busy_before_ignored_cmd", int'(busy), 1);
    func = 1'b1; in1 = 4'd6; in2 = 2'd2;
    @(negedge clk);
    func = 1'b0;
    ndone = 0;
    cq = '0;
    cr = '0;
    for (int n = 0; n < 12; n++) begin
      if (done) begin
        ndone++;
        cq = quot;
        cr = rem;
      end
      @(negedge clk);
    end
    check("ignored_cmd_done_count", ndone, 1);
    check("ignored_cmd_quot", int'(cq), 4);
    check("ignored_cmd_rem", int'(cr), 1);

    // Back-to-back: second command accepted in the first done cycle.
    run_op(4'd13, 2'd3, lat, nbusy);
    func = 1'b1; in1 = 4'd10; in2 = 2'd3;
    @(posedge clk);
    @(negedge clk);
    func     = 1'b0;
    k        = -1;
    held_bad = 0;
    for (int n = 1; n < 20; n++) begin
      if (done) begin
        k = n;
        break;
      end
      if (quot !== 4'd4 || rem !== 2'd1) held_bad++;
      @(negedge clk);
    end
    check("b2b_done_spacing", k, 5);
    check("b2b_prior_held", held_bad, 0);
    check("b2b_quot", int'(quot), 3);
    check("b2b_rem", int'(rem), 1);

    // Asynchronous reset in the middle of a calculation.
    @(negedge clk);
    func = 1'b1; in1 = 4'd13; in2 = 2'd3;
    @(posedge clk);
    @(negedge clk);
    func = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_quot", int'(quot), 0);
    check("midrst_rem", int'(rem), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_dbz", int'(div_by_zero), 0);
    ndone = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    rst = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("midrst_no_done", ndone, 0);
    run_op(4'd7, 2'd2, lat, nbusy);
    check("post_rst_lat", lat, 4);
    check("post_rst_quot", int'(quot), 3);
    check("post_rst_rem", int'(rem), 1);

    check("busy_done_overlap", overlap, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
